// File: rtl/alu_pkg.sv
// Shared opcode constants, sequencer state encoding and opcode legality check
// for the bit-serial ALU.
package alu_pkg;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic is_legal_op(input logic [2:0] op);
        return (op == OP_AND) || (op == OP_OR) || (op == OP_ADD) ||
               (op == OP_SUB) || (op == OP_SLT);
    endfunction

endpackage

// File: rtl/serial_alu_ctrl_if.sv
// Request/result bundle between a client (master) and the serial ALU sequencer (slave).
interface serial_alu_ctrl_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             zero;
    logic             illegal;

    modport master (
        output start, op, a, b,
        input  busy, done, result, cout, zero, illegal
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, result, cout, zero, illegal
    );
endinterface

// File: rtl/one_bit_alu.sv
// Combinational one-bit ALU slice: op[2] inverts b, op[1:0] selects AND/OR/SUM/LESS.
module one_bit_alu (
    input  logic       a,
    input  logic       b,
    input  logic       cin,
    input  logic       less,
    input  logic [2:0] op,
    output logic       r_c,
    output logic       cout_c
);
    logic b_eff;
    logic sum;

    assign b_eff  = b ^ op[2];
    assign sum    = a ^ b_eff ^ cin;
    assign cout_c = (a & b_eff) | (a & cin) | (b_eff & cin);

    always_comb begin
        r_c = 1'b0;
        case (op[1:0])
            2'b00:   r_c = a & b_eff;
            2'b01:   r_c = a | b_eff;
            2'b10:   r_c = sum;
            default: r_c = less;
        endcase
    end
endmodule

// File: rtl/serial_alu_ctrl.sv
// Bit-serial sequencer driving one one_bit_alu slice, LSB first, one bit per clock.
// Optional: define SERIAL_ALU_SLT_OVF_EN for overflow-corrected signed SLT.
module serial_alu_ctrl
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    serial_alu_ctrl_if.slave   bus
);
    localparam int unsigned CNT_W = $clog2(WIDTH);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             carry_reg;
    logic [2:0]       op_reg;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-2:0] res_sh;

    logic             slice_r_c;
    logic             slice_cout_c;
    logic             last_step_c;
    logic [WIDTH-1:0] full_word_c;
    logic             diff_msb_c;
    logic             set_c;
    logic [WIDTH-1:0] final_res_c;
    logic             final_cout_c;

    one_bit_alu u_slice (
        .a      (a_sh[0]),
        .b      (b_sh[0]),
        .cin    (carry_reg),
        .less   (1'b0),
        .op     (op_reg),
        .r_c    (slice_r_c),
        .cout_c (slice_cout_c)
    );

    // Result word as it stands once the current bit has been shifted in.
    assign full_word_c = {slice_r_c, res_sh};
    assign last_step_c = (cnt == CNT_W'(WIDTH - 1));

    // In SLT the slice returns 'less' on R, so the difference MSB is rebuilt here.
    assign diff_msb_c = a_sh[0] ^ ~b_sh[0] ^ carry_reg;
`ifdef SERIAL_ALU_SLT_OVF_EN
    assign set_c = diff_msb_c ^ (carry_reg ^ slice_cout_c);
`else
    assign set_c = diff_msb_c;
`endif

    assign final_res_c  = (op_reg == OP_SLT) ? {{(WIDTH-1){1'b0}}, set_c} : full_word_c;
    assign final_cout_c = (op_reg[1:0] == 2'b10) & slice_cout_c;

    // Sequencer: state, datapath shift registers and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            carry_reg   <= 1'b0;
            op_reg      <= '0;
            a_sh        <= '0;
            b_sh        <= '0;
            res_sh      <= '0;
            bus.busy    <= 1'b0;
            bus.done    <= 1'b0;
            bus.result  <= '0;
            bus.cout    <= 1'b0;
            bus.zero    <= 1'b0;
            bus.illegal <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        bus.busy <= 1'b1;
                        if (is_legal_op(bus.op)) begin
                            a_sh      <= bus.a;
                            b_sh      <= bus.b;
                            op_reg    <= bus.op;
                            carry_reg <= bus.op[2];
                            cnt       <= '0;
                            state     <= RUN;
                        end else begin
                            bus.result  <= '0;
                            bus.cout    <= 1'b0;
                            bus.zero    <= 1'b1;
                            bus.illegal <= 1'b1;
                            bus.done    <= 1'b1;
                            state       <= DONE;
                        end
                    end
                end
                RUN: begin
                    carry_reg <= slice_cout_c;
                    res_sh    <= full_word_c[WIDTH-1:1];
                    a_sh      <= a_sh >> 1;
                    b_sh      <= b_sh >> 1;
                    cnt       <= cnt + CNT_W'(1);
                    if (last_step_c) begin
                        bus.result  <= final_res_c;
                        bus.cout    <= final_cout_c;
                        bus.zero    <= (final_res_c == '0);
                        bus.illegal <= 1'b0;
                        bus.done    <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_alu_ctrl.sv
// Self-checking bench for serial_alu_ctrl: directed cases plus random ops
// against an arithmetic reference model.
module tb_serial_alu_ctrl;
    localparam int unsigned WIDTH = 32;

    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    serial_alu_ctrl_if #(.WIDTH(WIDTH)) bus ();

    serial_alu_ctrl #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference behaviour written directly from the arithmetic meaning of each opcode.
    task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] r, output logic c, output logic z, output logic ill);
        logic [32:0] s;
        r = '0; c = 1'b0; ill = 1'b0;
        case (op)
            3'b000: r = a & b;
            3'b001: r = a | b;
            3'b010: begin s = {1'b0, a} + {1'b0, b}; r = s[31:0]; c = s[32]; end
            3'b110: begin r = a - b; c = (a >= b); end
            3'b111: begin
`ifdef SERIAL_ALU_SLT_OVF_EN
                r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
`else
                s = {1'b0, a} - {1'b0, b};
                r = {31'b0, s[31]};
`endif
            end
            default: ill = 1'b1;
        endcase
        z = (r == 32'd0);
    endtask

    // Issue one request and check latency, busy, result flags and the single-cycle done.
    task automatic do_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int glitch_at);
        logic [31:0] er;
        logic        ec, ez, ei;
        int          n;
        bit          busy_ok;
        model(op, a, b, er, ec, ez, ei);
        @(negedge clk);
        bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.a = $urandom; bus.b = $urandom;
        n = 0; busy_ok = 1'b1;
        while (!bus.done && n < 100) begin
            if (!bus.busy) busy_ok = 1'b0;
            if (glitch_at > 0 && n == glitch_at) begin
                bus.start = 1'b1; bus.op = 3'b001; bus.a = ~a; bus.b = ~b;
            end
            @(posedge clk); #1;
            bus.start = 1'b0;
            n++;
        end
        check({tag, " latency"}, 64'(n), ei ? 64'd0 : 64'(WIDTH));
        check({tag, " busy"}, 64'(busy_ok && bus.busy), 64'd1);
        check({tag, " result"}, 64'(bus.result), 64'(er));
        check({tag, " cout"}, 64'(bus.cout), 64'(ec));
        check({tag, " zero"}, 64'(bus.zero), 64'(ez));
        check({tag, " illegal"}, 64'(bus.illegal), 64'(ei));
        @(posedge clk); #1;
        check({tag, " done_pulse"}, 64'(bus.done), 64'd0);
        check({tag, " busy_idle"}, 64'(bus.busy), 64'd0);
    endtask

    initial begin
        bit saw_done;
        logic [2:0] rop;
        rst = 1'b1;
        bus.start = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset busy", 64'(bus.busy), 64'd0);
        check("reset done", 64'(bus.done), 64'd0);
        check("reset result", 64'(bus.result), 64'd0);
        check("reset cout", 64'(bus.cout), 64'd0);
        check("reset zero", 64'(bus.zero), 64'd0);
        check("reset illegal", 64'(bus.illegal), 64'd0);
        rst = 1'b0;

        do_op("add_5_3", 3'b010, 32'd5, 32'd3, 0);
        do_op("sub_3_5", 3'b110, 32'd3, 32'd5, 0);
        do_op("sub_5_5", 3'b110, 32'd5, 32'd5, 0);
        do_op("slt_3_5", 3'b111, 32'd3, 32'd5, 0);
        do_op("slt_5_3", 3'b111, 32'd5, 32'd3, 0);
        do_op("slt_ovf", 3'b111, 32'h7FFF_FFFF, 32'h8000_0000, 0);
        do_op("and", 3'b000, 32'hF0F0_F0F0, 32'hFF00_FF00, 0);
        do_op("or", 3'b001, 32'hF0F0_F0F0, 32'hFF00_FF00, 0);
        do_op("add_wrap", 3'b010, 32'hFFFF_FFFF, 32'd1, 0);
        do_op("start_in_run", 3'b010, 32'h1234_5678, 32'h1111_1111, 10);
        do_op("illegal_011", 3'b011, 32'd7, 32'd9, 0);
        do_op("illegal_100", 3'b100, 32'd7, 32'd9, 0);
        do_op("illegal_101", 3'b101, 32'd7, 32'd9, 0);

        // Abandon an ADD halfway through with reset.
        do_op("pre_reset", 3'b001, 32'hA5A5_0000, 32'h0000_5A5A, 0);
        @(negedge clk);
        bus.start = 1'b1; bus.op = 3'b010; bus.a = 32'd100; bus.b = 32'd200;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (16) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrst busy", 64'(bus.busy), 64'd0);
        check("midrst done", 64'(bus.done), 64'd0);
        check("midrst result", 64'(bus.result), 64'd0);
        check("midrst cout", 64'(bus.cout), 64'd0);
        check("midrst zero", 64'(bus.zero), 64'd0);
        check("midrst illegal", 64'(bus.illegal), 64'd0);
        rst = 1'b0;
        saw_done = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus.done) saw_done = 1'b1;
        end
        check("midrst no_done", 64'(saw_done), 64'd0);
        do_op("post_reset_add", 3'b010, 32'd1000, 32'd2345, 0);

        for (int i = 0; i < 30; i++) begin
            rop = 3'($urandom_range(0, 7));
            do_op($sformatf("rand%0d_op%0d", i, rop), rop, $urandom, $urandom, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
